multi_break_counter: RTL and testbench

MULTI_BREAK_COUNTER -- requirements
Module: multi_break_counter

---
 rtl/multi_break_counter.sv | 168 ++++++++++++++++
 tb/tb_multi_break_counter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_break_counter.sv
// Chunked per-candidate break counter: masks clause-broken flags, sums them CHUNK_WIDTH at a time,
// and reports every candidate's count. Define MULTI_BREAK_MIN_SELECT_EN to also report the minimum.
module multi_break_counter #(
   parameter int NUM_CLAUSES      = 20,
   parameter int NUM_CANDIDATES   = 3,
   parameter int NUM_CLAUSES_BITS = 5,
   parameter int CHUNK_WIDTH      = 8,
   parameter int CAND_BITS        = 2
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       valid_i,
   output logic                                       ready_o,
   input  logic [NUM_CANDIDATES*NUM_CLAUSES-1:0]      clause_broken_i,
   input  logic [NUM_CLAUSES-1:0]                     mask_bits_i,
   output logic                                       valid_o,
   input  logic                                       ready_i,
   output logic [NUM_CANDIDATES*NUM_CLAUSES_BITS-1:0] break_values_o,
   output logic [NUM_CLAUSES_BITS-1:0]                min_value_o,
   output logic [CAND_BITS-1:0]                       min_index_o,
   output logic [1:0]                                 dbg_state_o
);

   // Handshake: a request transfers on a rising edge with valid_i && ready_o; a result
   // transfers on a rising edge with valid_o && ready_i. Outputs hold while valid_o waits.

   localparam int NUM_CHUNKS = (NUM_CLAUSES + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
   localparam int NUM_SLOTS  = NUM_CHUNKS + 1;
   localparam int PAD_W      = NUM_SLOTS * CHUNK_WIDTH;
   localparam int CNT_W      = $clog2(NUM_SLOTS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                      state_q, state_d;
   logic [CNT_W-1:0]            chunk_q, chunk_d;
   logic [CHUNK_WIDTH-1:0]      broken_q  [NUM_CANDIDATES][NUM_SLOTS];
   logic [CHUNK_WIDTH-1:0]      broken_d  [NUM_CANDIDATES][NUM_SLOTS];
   logic [NUM_CLAUSES_BITS-1:0] acc_q     [NUM_CANDIDATES];
   logic [NUM_CLAUSES_BITS-1:0] acc_d     [NUM_CANDIDATES];
   logic [NUM_CLAUSES_BITS-1:0] chunk_pop [NUM_CANDIDATES];
   logic [PAD_W-1:0]            load_vec  [NUM_CANDIDATES];
   logic                        last_chunk;

   // The extra all-zero slot beyond the final chunk keeps the last COUNT cycle in range
   // and makes the clause bits above NUM_CLAUSES count as zero.
   for (genvar c = 0; c < NUM_CANDIDATES; c++) begin : g_cand
      assign load_vec[c] = PAD_W'(clause_broken_i[c*NUM_CLAUSES +: NUM_CLAUSES] & mask_bits_i);
      assign break_values_o[c*NUM_CLAUSES_BITS +: NUM_CLAUSES_BITS] = acc_q[c];
   end

   assign last_chunk  = (chunk_q == CNT_W'(NUM_CHUNKS));
   assign ready_o     = (state_q == IDLE);
   assign valid_o     = (state_q == DONE);
   assign dbg_state_o = state_q;

   always_comb begin
      for (int c = 0; c < NUM_CANDIDATES; c++) begin
         chunk_pop[c] = '0;
         for (int b = 0; b < CHUNK_WIDTH; b++) begin
            chunk_pop[c] = chunk_pop[c] + NUM_CLAUSES_BITS'(broken_q[c][chunk_q][b]);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      chunk_d = chunk_q;
      for (int c = 0; c < NUM_CANDIDATES; c++) begin
         acc_d[c] = acc_q[c];
         for (int j = 0; j < NUM_SLOTS; j++) begin
            broken_d[c][j] = broken_q[c][j];
         end
      end
      unique case (state_q)
         IDLE: begin
            if (valid_i) begin
               state_d = COUNT;
               chunk_d = '0;
               for (int c = 0; c < NUM_CANDIDATES; c++) begin
                  acc_d[c] = '0;
                  for (int j = 0; j < NUM_SLOTS; j++) begin
                     broken_d[c][j] = load_vec[c][j*CHUNK_WIDTH +: CHUNK_WIDTH];
                  end
               end
            end
         end
         COUNT: begin
            // The cycle after the final chunk lets the minimum see settled accumulators.
            if (last_chunk) begin
               state_d = DONE;
            end else begin
               chunk_d = chunk_q + CNT_W'(1);
               for (int c = 0; c < NUM_CANDIDATES; c++) begin
                  acc_d[c] = acc_q[c] + chunk_pop[c];
               end
            end
         end
         DONE: begin
            if (ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         chunk_q <= '0;
         for (int c = 0; c < NUM_CANDIDATES; c++) begin
            acc_q[c] <= '0;
            for (int j = 0; j < NUM_SLOTS; j++) begin
               broken_q[c][j] <= '0;
            end
         end
      end else begin
         state_q <= state_d;
         chunk_q <= chunk_d;
         for (int c = 0; c < NUM_CANDIDATES; c++) begin
            acc_q[c] <= acc_d[c];
            for (int j = 0; j < NUM_SLOTS; j++) begin
               broken_q[c][j] <= broken_d[c][j];
            end
         end
      end
   end

`ifdef MULTI_BREAK_MIN_SELECT_EN
   logic [NUM_CLAUSES_BITS-1:0] min_value_q, min_value_d;
   logic [CAND_BITS-1:0]        min_index_q, min_index_d;

   // Strict less-than keeps the lowest index on ties.
   always_comb begin
      min_value_d = acc_q[0];
      min_index_d = '0;
      for (int c = 1; c < NUM_CANDIDATES; c++) begin
         if (acc_q[c] < min_value_d) begin
            min_value_d = acc_q[c];
            min_index_d = CAND_BITS'(c);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         min_value_q <= '0;
         min_index_q <= '0;
      end else if (state_q == COUNT && last_chunk) begin
         min_value_q <= min_value_d;
         min_index_q <= min_index_d;
      end
   end

   assign min_value_o = min_value_q;
   assign min_index_o = min_index_q;
`else
   assign min_value_o = '0;
   assign min_index_o = '0;
`endif

endmodule

// File: tb/tb_multi_break_counter.sv
// Directed self-checking bench for multi_break_counter; minimum expectations follow
// whether MULTI_BREAK_MIN_SELECT_EN is defined for the build.
module tb_multi_break_counter;

`ifdef MULTI_BREAK_MIN_SELECT_EN
   localparam bit MIN_EN = 1'b1;
`else
   localparam bit MIN_EN = 1'b0;
`endif
   localparam int LAT = 4;

   logic        clk;
   logic        reset;
   logic        valid_i;
   logic        ready_o;
   logic [59:0] clause_broken_i;
   logic [19:0] mask_bits_i;
   logic        valid_o;
   logic        ready_i;
   logic [14:0] break_values_o;
   logic [4:0]  min_value_o;
   logic [1:0]  min_index_o;
   logic [1:0]  dbg_state_o;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [21:0] exp_q[$];

   multi_break_counter dut (
      .clk             (clk),
      .reset           (reset),
      .valid_i         (valid_i),
      .ready_o         (ready_o),
      .clause_broken_i (clause_broken_i),
      .mask_bits_i     (mask_bits_i),
      .valid_o         (valid_o),
      .ready_i         (ready_i),
      .break_values_o  (break_values_o),
      .min_value_o     (min_value_o),
      .min_index_o     (min_index_o),
      .dbg_state_o     (dbg_state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // drivers: called at posedge+1 with the DUT in IDLE; lat = edges from accept to valid_o, -1 on timeout
   task automatic run_req(input logic [59:0] br, input logic [19:0] mk, output int lat);
      clause_broken_i = br;
      mask_bits_i     = mk;
      valid_i         = 1'b1;
      @(posedge clk); #1;
      valid_i         = 1'b0;
      clause_broken_i = '1;
      mask_bits_i     = '1;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (valid_o === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic release_result();
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      n_cmp++;
      if ({dbg_state_o, ready_o, valid_o, break_values_o, min_value_o, min_index_o} !== {2'd0, 1'b1, 1'b0, 15'd0, 5'd0, 2'd0}) begin
         n_fail++;
         $display("FAIL reset_state: got st=%0d rdy=%b vld=%b bv=%h mv=%0d mi=%0d want st=0 rdy=1 vld=0 bv=0 mv=0 mi=0",
                  dbg_state_o, ready_o, valid_o, break_values_o, min_value_o, min_index_o);
      end
   endtask

   task automatic test_single_full();
      int lat;
      run_req({20'h0, 20'h0, 20'hFFFFF}, 20'hFFFFF, lat);
      n_cmp++;
      if (lat !== LAT) begin n_fail++; $display("FAIL full_latency: got %0d want %0d", lat, LAT); end
      n_cmp++;
      if (break_values_o !== {5'd0, 5'd0, 5'd20}) begin
         n_fail++; $display("FAIL full_values: got %h want %h", break_values_o, {5'd0, 5'd0, 5'd20});
      end
      n_cmp++;
      if ({min_value_o, min_index_o} !== (MIN_EN ? {5'd0, 2'd1} : 7'd0)) begin
         n_fail++; $display("FAIL full_min: got mv=%0d mi=%0d", min_value_o, min_index_o);
      end
      release_result();
      n_cmp++;
      if ({ready_o, valid_o} !== 2'b10) begin
         n_fail++; $display("FAIL full_release: got rdy=%b vld=%b want rdy=1 vld=0", ready_o, valid_o);
      end
   endtask

   task automatic test_mask();
      int lat;
      run_req({60{1'b1}}, 20'h0, lat);
      n_cmp++;
      if ({break_values_o, min_value_o, min_index_o} !== 22'd0 || lat !== LAT) begin
         n_fail++; $display("FAIL mask_zero: got bv=%h mv=%0d mi=%0d lat=%0d want all 0 lat=%0d",
                            break_values_o, min_value_o, min_index_o, lat, LAT);
      end
      release_result();
      run_req({20'h00001, 20'hAAAAA, 20'hFFFFF}, 20'h0F0F0, lat);
      n_cmp++;
      if (break_values_o !== {5'd0, 5'd4, 5'd8}) begin
         n_fail++; $display("FAIL mask_partial: got %h want %h", break_values_o, {5'd0, 5'd4, 5'd8});
      end
      n_cmp++;
      if ({min_value_o, min_index_o} !== (MIN_EN ? {5'd0, 2'd2} : 7'd0)) begin
         n_fail++; $display("FAIL mask_partial_min: got mv=%0d mi=%0d", min_value_o, min_index_o);
      end
      release_result();
   endtask

   task automatic test_min_tie();
      int lat;
      run_req({20'h7F000, 20'h80F00, 20'h0001F}, 20'hFFFFF, lat);
      n_cmp++;
      if (break_values_o !== {5'd7, 5'd5, 5'd5}) begin
         n_fail++; $display("FAIL tie_values: got %h want %h", break_values_o, {5'd7, 5'd5, 5'd5});
      end
      n_cmp++;
      if ({min_value_o, min_index_o} !== (MIN_EN ? {5'd5, 2'd0} : 7'd0)) begin
         n_fail++; $display("FAIL tie_min: got mv=%0d mi=%0d", min_value_o, min_index_o);
      end
      release_result();
   endtask

   task automatic test_partial_chunk();
      int lat;
      run_req({20'hF0000, 20'h00000, 20'h00003}, 20'hFFFFF, lat);
      n_cmp++;
      if (break_values_o !== {5'd4, 5'd0, 5'd2}) begin
         n_fail++; $display("FAIL partial_chunk: got %h want %h", break_values_o, {5'd4, 5'd0, 5'd2});
      end
      n_cmp++;
      if ({min_value_o, min_index_o} !== (MIN_EN ? {5'd0, 2'd1} : 7'd0)) begin
         n_fail++; $display("FAIL partial_chunk_min: got mv=%0d mi=%0d", min_value_o, min_index_o);
      end
      release_result();
   endtask

   task automatic test_hold_done();
      int lat;
      run_req({20'h7F000, 20'h80F00, 20'h0001F}, 20'hFFFFF, lat);
      for (int i = 0; i < 4; i++) begin
         valid_i         = (i == 1);
         clause_broken_i = '0;
         mask_bits_i     = 20'hFFFFF;
         @(posedge clk); #1;
         n_cmp++;
         if ({valid_o, ready_o, break_values_o} !== {1'b1, 1'b0, 5'd7, 5'd5, 5'd5} ||
             {min_value_o, min_index_o} !== (MIN_EN ? {5'd5, 2'd0} : 7'd0)) begin
            n_fail++; $display("FAIL hold_done[%0d]: got vld=%b rdy=%b bv=%h mv=%0d mi=%0d", i,
                               valid_o, ready_o, break_values_o, min_value_o, min_index_o);
         end
      end
      valid_i = 1'b0;
      release_result();
      n_cmp++;
      if ({dbg_state_o, ready_o, valid_o} !== {2'd0, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL hold_release: got st=%0d rdy=%b vld=%b want st=0 rdy=1 vld=0",
                            dbg_state_o, ready_o, valid_o);
      end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (dbg_state_o !== 2'd0) begin
         n_fail++; $display("FAIL hold_pulse_ignored: got st=%0d want 0", dbg_state_o);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      clause_broken_i = {60{1'b1}};
      mask_bits_i     = 20'hFFFFF;
      valid_i         = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_cmp++;
      if ({dbg_state_o, ready_o, valid_o, break_values_o, min_value_o, min_index_o} !== {2'd0, 1'b1, 1'b0, 15'd0, 5'd0, 2'd0}) begin
         n_fail++; $display("FAIL reset_count: got st=%0d rdy=%b vld=%b bv=%h mv=%0d mi=%0d",
                            dbg_state_o, ready_o, valid_o, break_values_o, min_value_o, min_index_o);
      end
      run_req({20'h00001, 20'h00003, 20'h00007}, 20'hFFFFF, lat);
      n_cmp++;
      if (lat !== LAT || break_values_o !== {5'd1, 5'd2, 5'd3}) begin
         n_fail++; $display("FAIL reset_recover: got lat=%0d bv=%h want lat=%0d bv=%h",
                            lat, break_values_o, LAT, {5'd1, 5'd2, 5'd3});
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_cmp++;
      if ({dbg_state_o, valid_o, break_values_o, min_value_o, min_index_o} !== {2'd0, 1'b0, 15'd0, 5'd0, 2'd0}) begin
         n_fail++; $display("FAIL reset_done: got st=%0d vld=%b bv=%h mv=%0d mi=%0d",
                            dbg_state_o, valid_o, break_values_o, min_value_o, min_index_o);
      end
      reset   = 1'b1;
      valid_i = 1'b1;
      @(posedge clk); #1;
      reset   = 1'b0;
      valid_i = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({dbg_state_o, ready_o} !== {2'd0, 1'b1}) begin
         n_fail++; $display("FAIL reset_with_valid: got st=%0d rdy=%b want st=0 rdy=1", dbg_state_o, ready_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [59:0] br_tab [3];
      logic [21:0] got, want;
      int lat, waited;
      br_tab[0] = {20'h00007, 20'h00003, 20'h00001};
      br_tab[1] = {20'hFFFF0, 20'h0FFFF, 20'hFFFFF};
      br_tab[2] = {20'h80000, 20'h00000, 20'h12345};
      exp_q.push_back({5'd3,  5'd2,  5'd1,  (MIN_EN ? {5'd1,  2'd0} : 7'd0)});
      exp_q.push_back({5'd16, 5'd16, 5'd20, (MIN_EN ? {5'd16, 2'd1} : 7'd0)});
      exp_q.push_back({5'd1,  5'd0,  5'd7,  (MIN_EN ? {5'd0,  2'd1} : 7'd0)});
      ready_i = 1'b1;
      for (int r = 0; r < 3; r++) begin
         waited = 0;
         while (ready_o !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
         end
         run_req(br_tab[r], 20'hFFFFF, lat);
         got  = {break_values_o, min_value_o, min_index_o};
         want = exp_q.pop_front();
         n_cmp++;
         if (lat !== LAT || got !== want) begin
            n_fail++; $display("FAIL b2b[%0d]: got lat=%0d res=%h want lat=%0d res=%h", r, lat, got, LAT, want);
         end
      end
      @(posedge clk); #1;
      ready_i = 1'b0;
   endtask

   initial begin
      reset           = 1'b0;
      valid_i         = 1'b0;
      ready_i         = 1'b0;
      clause_broken_i = '0;
      mask_bits_i     = '0;
      @(posedge clk); #1;
      test_reset();
      test_single_full();
      test_mask();
      test_min_tie();
      test_partial_chunk();
      test_hold_done();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
